// File: rtl/operand_select_stage_pkg.sv
// Shared encodings and defaults for the operand select stage and its
// combinational selector.
package operand_select_stage_pkg;

  localparam int DEFAULT_WIDTH = 32;
  localparam int DEFAULT_IMM_W = 16;
  localparam int DEFAULT_TAG_W = 5;

  typedef enum logic [1:0] {
    SELA_REG1 = 2'd0,
    SELA_HI   = 2'd1,
    SELA_LO   = 2'd2,
    SELA_PC   = 2'd3
  } sel_a_e;

  typedef enum logic [1:0] {
    SELB_REG2  = 2'd0,
    SELB_ZEXT  = 2'd1,
    SELB_SEXT  = 2'd2,
    SELB_UPPER = 2'd3
  } sel_b_e;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } stage_state_e;

endpackage

// File: rtl/operand_select_comb.sv
// Pure combinational A/B operand selection with half-word masking and
// immediate extension/placement; shared with the single-cycle core.
module operand_select_comb
  import operand_select_stage_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int IMM_W = DEFAULT_IMM_W
) (
  input  logic [1:0]       sel_a,
  input  logic [1:0]       sel_b,
  input  logic [WIDTH-1:0] pc,
  input  logic [WIDTH-1:0] reg_1,
  input  logic [WIDTH-1:0] reg_2,
  input  logic [IMM_W-1:0] imm,
  output logic [WIDTH-1:0] an,
  output logic [WIDTH-1:0] am
);

  localparam logic [WIDTH-1:0] HI_KEEP = {{(WIDTH/2){1'b1}}, {(WIDTH/2){1'b0}}};

  logic [WIDTH-1:0] imm_zext;
  logic [WIDTH-1:0] imm_sext;
  logic [WIDTH-1:0] imm_upper;

  // Casts collapse to plain IMM when WIDTH == IMM_W, so no zero-width replication.
  assign imm_zext  = WIDTH'(imm);
  assign imm_sext  = WIDTH'($signed(imm));
  assign imm_upper = imm_zext << (WIDTH - IMM_W);

  always_comb begin
    an = reg_1;
    case (sel_a_e'(sel_a))
      SELA_REG1: an = reg_1;
      SELA_HI:   an = reg_1 & HI_KEEP;
      SELA_LO:   an = reg_1 & ~HI_KEEP;
      SELA_PC:   an = pc;
      default:   an = reg_1;
    endcase
  end

  always_comb begin
    am = reg_2;
    case (sel_b_e'(sel_b))
      SELB_REG2:  am = reg_2;
      SELB_ZEXT:  am = imm_zext;
      SELB_SEXT:  am = imm_sext;
      SELB_UPPER: am = imm_upper;
      default:    am = reg_2;
    endcase
  end

endmodule

// File: rtl/operand_select_stage.sv
// Registered operand select stage: valid/ready handshake with a 2-entry
// skid buffer so throughput stays at one op per cycle under back-pressure.
module operand_select_stage
  import operand_select_stage_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int IMM_W = DEFAULT_IMM_W,
  parameter int TAG_W = DEFAULT_TAG_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] pc,
  input  logic [WIDTH-1:0] reg_1,
  input  logic [WIDTH-1:0] reg_2,
  input  logic [IMM_W-1:0] imm,
  input  logic [1:0]       sel_a,
  input  logic [1:0]       sel_b,
  input  logic [TAG_W-1:0] tag_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] an,
  output logic [WIDTH-1:0] am,
  output logic [TAG_W-1:0] tag_out
);

  localparam int ENTRY_W = 2 * WIDTH + TAG_W;

  stage_state_e     state_r;
  stage_state_e     state_next;
  logic             in_ready_r;
  logic [ENTRY_W-1:0] main_r;
  logic [ENTRY_W-1:0] skid_r;
  logic [ENTRY_W-1:0] new_entry;
  logic [WIDTH-1:0] sel_an;
  logic [WIDTH-1:0] sel_am;
  logic             accept;
  logic             transfer;

  operand_select_comb #(
    .WIDTH(WIDTH),
    .IMM_W(IMM_W)
  ) u_select (
    .sel_a (sel_a),
    .sel_b (sel_b),
    .pc    (pc),
    .reg_1 (reg_1),
    .reg_2 (reg_2),
    .imm   (imm),
    .an    (sel_an),
    .am    (sel_am)
  );

  assign new_entry = {sel_an, sel_am, tag_in};
  assign accept    = in_valid & in_ready_r;
  assign transfer  = out_valid & out_ready;
  assign in_ready  = in_ready_r;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= ST_EMPTY;
      in_ready_r <= 1'b1;
    end else begin
      state_r    <= state_next;
      in_ready_r <= (state_next != ST_TWO);
    end
  end

  always_comb begin
    state_next = state_r;
    case (state_r)
      ST_EMPTY: begin
        if (accept) state_next = ST_ONE;
        else        state_next = ST_EMPTY;
      end
      ST_ONE: begin
        if (accept && !transfer)      state_next = ST_TWO;
        else if (!accept && transfer) state_next = ST_EMPTY;
        else                          state_next = ST_ONE;
      end
      ST_TWO: begin
        if (transfer) state_next = ST_ONE;
        else          state_next = ST_TWO;
      end
      default: state_next = ST_EMPTY;
    endcase
  end

  // Data only moves on accept/transfer, so undriven inputs never reach the outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_r <= '0;
      skid_r <= '0;
    end else begin
      case (state_r)
        ST_EMPTY: if (accept) main_r <= new_entry;
        ST_ONE: begin
          if (accept && transfer) main_r <= new_entry;
          else if (accept)        skid_r <= new_entry;
        end
        ST_TWO:   if (transfer) main_r <= skid_r;
        default: ;
      endcase
    end
  end

  always_comb begin
    out_valid = (state_r != ST_EMPTY);
    {an, am, tag_out} = main_r;
  end

endmodule
